// File: rtl/run_controller.sv
// Host-side launcher for the core's Reset/Start/Ack handshake: resets the core,
// pulses Start, then counts RUN cycles until Ack or timeout and reports with Done.
module run_controller #(
    parameter int          RST_CYCLES   = 2,
    parameter int          START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'hFFFF,
    parameter int          NPROG        = 3,
    parameter int          PW           = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic [PW-1:0] ProgSel,
    input  logic          CoreAck,
    output logic          CoreReset,
    output logic          CoreStart,
    output logic [PW-1:0] CoreProg,
    output logic          Busy,
    output logic          Done,
    output logic          TimedOut,
    output logic          BadProg,
    output logic [15:0]   CycleCt
);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_START, S_RUN, S_FIN} state_t;

    localparam logic [PW:0] NPROG_W   = (PW+1)'(NPROG);
    localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
    localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);

    state_t        state_q, state_d;
    logic [15:0]   phase_q, phase_d;
    logic          core_reset_q, core_reset_d;
    logic          core_start_q, core_start_d;
    logic [PW-1:0] core_prog_q, core_prog_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timed_out_q, timed_out_d;
    logic          bad_prog_q, bad_prog_d;
    logic [15:0]   cycle_ct_q, cycle_ct_d;
    logic [15:0]   cycle_ct_inc;

    assign cycle_ct_inc = cycle_ct_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        core_reset_d = core_reset_q;
        core_start_d = core_start_q;
        core_prog_d  = core_prog_q;
        timed_out_d  = timed_out_q;
        cycle_ct_d   = cycle_ct_q;
        done_d       = 1'b0;
        bad_prog_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                core_start_d = 1'b0;
                if (Go) begin
                    if ({1'b0, ProgSel} < NPROG_W) begin
                        core_prog_d  = ProgSel;
                        cycle_ct_d   = 16'd0;
                        timed_out_d  = 1'b0;
                        core_reset_d = 1'b1;
                        phase_d      = 16'd0;
                        state_d      = S_RST;
                    end else begin
                        bad_prog_d = 1'b1;
                    end
                end
            end
            S_RST: begin
                if (phase_q == RST_LAST) begin
                    core_reset_d = 1'b0;
                    core_start_d = 1'b1;
                    phase_d      = 16'd0;
                    state_d      = S_START;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_START: begin
                if (phase_q == START_LAST) begin
                    core_start_d = 1'b0;
                    state_d      = S_RUN;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_RUN: begin
                // Ack takes precedence over the timeout boundary on the same cycle.
                if (CoreAck) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    cycle_ct_d = cycle_ct_inc;
                    if (cycle_ct_inc == TIMEOUT) begin
                        timed_out_d  = 1'b1;
                        core_reset_d = 1'b1;
                        done_d       = 1'b1;
                        state_d      = S_FIN;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RST) || (state_d == S_START) || (state_d == S_RUN);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            phase_q      <= 16'd0;
            core_reset_q <= 1'b1;
            core_start_q <= 1'b0;
            core_prog_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            bad_prog_q   <= 1'b0;
            cycle_ct_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            core_reset_q <= core_reset_d;
            core_start_q <= core_start_d;
            core_prog_q  <= core_prog_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timed_out_q  <= timed_out_d;
            bad_prog_q   <= bad_prog_d;
            cycle_ct_q   <= cycle_ct_d;
        end
    end

    assign CoreReset = core_reset_q;
    assign CoreStart = core_start_q;
    assign CoreProg  = core_prog_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign TimedOut  = timed_out_q;
    assign BadProg   = bad_prog_q;
    assign CycleCt   = cycle_ct_q;

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Host-side launcher that drives the processor core's Reset/Start/Ack handshake. It is the initiator for the core's done-flag protocol.
- On a Go request it resets the core, holds Start, then waits for Ack.
- It counts run cycles, enforces a timeout, and reports completion with a one-cycle Done pulse.
- It sits between the bench/host sequencer and the core's top-level Reset, Start and Ack ports.

Parameters:
RST_CYCLES, 2, cycles CoreReset is held high per launch (>=1)
START_CYCLES, 2, cycles CoreStart is held high after reset (>=1)
TIMEOUT, 16'hFFFF, maximum RUN cycles before abort (>=1)
NPROG, 3, number of valid program indices
PW, 2, width of program index

Ports:
Clk  in  1  clock, posedge only
Reset  in  1  asynchronous, active-high reset of this block
Go  in  1  launch request, sampled in IDLE only
ProgSel  in  PW  program index to launch
CoreAck  in  1  done flag from the core
CoreReset  out  1  reset to the core
CoreStart  out  1  start to the core
CoreProg  out  PW  latched program index presented to the core
Busy  out  1  high in RST, START and RUN states
Done  out  1  one-cycle pulse at end of a run (normal or timeout)
TimedOut  out  1  sticky; set on timeout, cleared by the next accepted Go
BadProg  out  1  one-cycle pulse when Go is rejected
CycleCt  out  16  RUN cycles counted for the current or last run

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run) forces:
  - state=IDLE, CoreReset=1, CoreStart=0, CoreProg=0
  - Busy=0, Done=0, TimedOut=0, BadProg=0, CycleCt=0
  - Reset has priority over every other input.
- All outputs are registered.
- States: IDLE, RST, START, RUN, FIN.
- IDLE:
  - CoreReset holds its last value; CoreStart=0.
  - Go=1 with ProgSel<NPROG: latch ProgSel into CoreProg, clear CycleCt and TimedOut, set CoreReset=1, go to RST.
  - Go=1 with ProgSel>=NPROG: BadProg=1 for one cycle; remain in IDLE; CoreProg, CycleCt and TimedOut are unchanged.
- RST:
  - CoreReset=1 for exactly RST_CYCLES cycles, then CoreReset=0, CoreStart=1, go to START.
- START:
  - CoreStart=1 for exactly START_CYCLES cycles, then CoreStart=0, go to RUN.
  - CoreAck is ignored in RST and START (a stale halt from the previous run must not end the new one).
- RUN:
  - CoreAck=1: go to FIN without incrementing CycleCt.
  - CoreAck=0: CycleCt+1. If the new value equals TIMEOUT: set TimedOut=1, CoreReset=1, go to FIN.
  - When Ack and the timeout boundary coincide, Ack wins.
  - CycleCt never exceeds TIMEOUT and never wraps.
- FIN:
  - Done=1 for exactly one cycle, Busy=0, then IDLE.
  - After a timeout, CoreReset stays 1 through FIN and IDLE until the next launch.
  - After a normal completion, CoreReset stays 0 so the halted core (Ack high) and its memory remain observable.
- Go while Busy or in FIN is ignored; no queueing.
- Launch latency: an accepted Go at edge N gives:
  - CoreReset high for edges N+1 .. N+RST_CYCLES
  - CoreStart high for the next START_CYCLES edges
  - first RUN cycle at edge N+RST_CYCLES+START_CYCLES+1
- CycleCt holds its final value after FIN until the next accepted Go.

Test Plan:
1. Reset then idle 5 cycles -> CoreReset=1, CoreStart=0, Busy=0, Done=0, CycleCt=0 throughout.
2. Go=1, ProgSel=1; core asserts CoreAck after 7 RUN cycles -> CoreProg=1; CoreReset high 2 cycles; CoreStart high 2 cycles; CycleCt=7; one Done pulse; TimedOut=0; CoreReset stays 0 in IDLE.
3. TIMEOUT=20, CoreAck held 0 -> CycleCt=20, TimedOut=1, CoreReset=1, one Done pulse. A following Go clears TimedOut to 0 on the launch edge.
4. CoreAck held 1 from before Go (stale halt) -> ignored during RST/START. First RUN cycle sees Ack: CycleCt=0, Done pulses.
5. Go with ProgSel=3 (NPROG=3) -> BadProg one-cycle pulse, no state change. Go pulses during RUN -> ignored, CycleCt unaffected.
6. Reset asserted mid-RUN at CycleCt=5 -> immediately CoreReset=1, CoreStart=0, CycleCt=0, Busy=0, no Done pulse. TIMEOUT=20 with Ack arriving on the 20th RUN cycle -> Ack wins: CycleCt=19, TimedOut=0.
